// File: rtl/mul_accum_pkg.sv
// Shared types and readout-geometry helpers for the serial-load multiply-accumulate harness.
package mul_accum_pkg;

  // Fixed product carrier width; ACC_WIDTH must stay below this so the carry bits exist.
  localparam int unsigned ProdMaxW = 64;

  typedef struct packed {
    logic                valid;
    logic                acc_en;
    logic [ProdMaxW-1:0] product;
  } pipe_entry_t;

  function automatic int unsigned seg_count(input int unsigned width, input int unsigned seg_w);
    return (width + seg_w - 1) / seg_w;
  endfunction

  function automatic int unsigned sel_width(input int unsigned nseg);
    return (nseg > 1) ? $clog2(nseg) : 1;
  endfunction

  function automatic int unsigned a_offset(input int unsigned nseg_acc);
    return nseg_acc;
  endfunction

  function automatic int unsigned b_offset(input int unsigned nseg_acc, input int unsigned nseg_a);
    return nseg_acc + nseg_a;
  endfunction

endpackage

// File: rtl/mul_accum_harness_mul_pipe.sv
// Operand-to-product pipeline: multiplies the low operand bits and carries valid/acc_en alongside.
module mul_pipe
  import mul_accum_pkg::*;
#(
  parameter int unsigned MUL_WIDTH = 13,
  parameter int unsigned STAGES    = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  input  logic                 in_acc_en_i,
  input  logic [MUL_WIDTH-1:0] op_a_i,
  input  logic [MUL_WIDTH-1:0] op_b_i,
  output pipe_entry_t          out_o,
  output logic                 busy_o
);

  pipe_entry_t [STAGES-1:0] stage_q, stage_d;
  logic [2*MUL_WIDTH-1:0]   prod;

  always_comb begin
    prod = {{MUL_WIDTH{1'b0}}, op_a_i} * {{MUL_WIDTH{1'b0}}, op_b_i};
    stage_d = stage_q;
    stage_d[0].valid   = in_valid_i;
    stage_d[0].acc_en  = in_acc_en_i;
    stage_d[0].product = ProdMaxW'(prod);
    for (int unsigned i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    busy_o = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      busy_o = busy_o | stage_q[i].valid;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_o = stage_q[STAGES-1];

endmodule

// File: rtl/mul_accum_harness.sv
// Serial-load operand capture, pipelined multiply, overwrite/accumulate with sticky overflow,
// and a byte-segment readout of accumulator and operands.
module mul_accum_harness
  import mul_accum_pkg::*;
#(
  parameter int unsigned A_WIDTH   = 16,
  parameter int unsigned B_WIDTH   = 16,
  parameter int unsigned MUL_WIDTH = 13,
  parameter int unsigned STAGES    = 2,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned OUT_WIDTH = 8,
  localparam int unsigned SEL_W = sel_width(seg_count(ACC_WIDTH, OUT_WIDTH) +
                                            seg_count(A_WIDTH, OUT_WIDTH) +
                                            seg_count(B_WIDTH, OUT_WIDTH))
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sin_a,
  input  logic                 sin_b,
  input  logic                 shift_en,
  input  logic                 capture,
  input  logic                 acc_en,
  input  logic                 acc_clr,
  input  logic [SEL_W-1:0]     rd_sel,
  output logic [OUT_WIDTH-1:0] rd_data,
  output logic                 busy,
  output logic                 res_valid,
  output logic                 ovf
);

  localparam int unsigned NsegAcc = seg_count(ACC_WIDTH, OUT_WIDTH);
  localparam int unsigned NsegA   = seg_count(A_WIDTH, OUT_WIDTH);
  localparam int unsigned NsegB   = seg_count(B_WIDTH, OUT_WIDTH);
  localparam int unsigned AOff    = a_offset(NsegAcc);
  localparam int unsigned BOff    = b_offset(NsegAcc, NsegA);
  localparam int unsigned AccPadW = NsegAcc * OUT_WIDTH;
  localparam int unsigned APadW   = NsegA * OUT_WIDTH;
  localparam int unsigned BPadW   = NsegB * OUT_WIDTH;

  logic [A_WIDTH-1:0]   sr_a_q, op_a_q;
  logic [B_WIDTH-1:0]   sr_b_q, op_b_q;
  logic                 cap_vld_q, cap_acc_en_q;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic                 wrote_q, wrote_d;
  logic                 pipe_busy;
  pipe_entry_t          pipe_out;
  logic [ProdMaxW-1:0]  sum;

  mul_pipe #(
    .MUL_WIDTH (MUL_WIDTH),
    .STAGES    (STAGES)
  ) u_mul_pipe (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (cap_vld_q),
    .in_acc_en_i (cap_acc_en_q),
    .op_a_i      (op_a_q[MUL_WIDTH-1:0]),
    .op_b_i      (op_b_q[MUL_WIDTH-1:0]),
    .out_o       (pipe_out),
    .busy_o      (pipe_busy)
  );

  // A clear coinciding with a write forces overwrite semantics for that write.
  always_comb begin
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    wrote_d = wrote_q;
    sum     = ProdMaxW'(acc_q) + pipe_out.product;
    if (acc_clr) begin
      acc_d   = '0;
      ovf_d   = 1'b0;
      wrote_d = 1'b0;
    end
    if (pipe_out.valid) begin
      wrote_d = 1'b1;
      if (pipe_out.acc_en && !acc_clr) begin
        acc_d = sum[ACC_WIDTH-1:0];
        ovf_d = ovf_q | (|sum[ProdMaxW-1:ACC_WIDTH]);
      end else begin
        acc_d = pipe_out.product[ACC_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_a_q       <= '0;
      sr_b_q       <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      cap_vld_q    <= 1'b0;
      cap_acc_en_q <= 1'b0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      wrote_q      <= 1'b0;
    end else begin
      if (shift_en) begin
        sr_a_q <= {sr_a_q[A_WIDTH-2:0], sin_a};
        sr_b_q <= {sr_b_q[B_WIDTH-2:0], sin_b};
      end
      if (capture) begin
        op_a_q <= sr_a_q;
        op_b_q <= sr_b_q;
      end
      cap_vld_q    <= capture;
      cap_acc_en_q <= capture & acc_en;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      wrote_q      <= wrote_d;
    end
  end

  assign busy      = cap_vld_q | pipe_busy;
  assign res_valid = wrote_q & ~busy;
  assign ovf       = ovf_q;

  logic [AccPadW-1:0] acc_pad;
  logic [APadW-1:0]   a_pad;
  logic [BPadW-1:0]   b_pad;
  int unsigned        sel;

  always_comb begin
    acc_pad = AccPadW'(acc_q);
    a_pad   = APadW'(op_a_q);
    b_pad   = BPadW'(op_b_q);
    sel     = 32'(rd_sel);
    rd_data = '0;
    for (int unsigned i = 0; i < NsegAcc; i++) begin
      if (sel == i) rd_data = acc_pad[i*OUT_WIDTH +: OUT_WIDTH];
    end
    for (int unsigned i = 0; i < NsegA; i++) begin
      if (sel == AOff + i) rd_data = a_pad[i*OUT_WIDTH +: OUT_WIDTH];
    end
    for (int unsigned i = 0; i < NsegB; i++) begin
      if (sel == BOff + i) rd_data = b_pad[i*OUT_WIDTH +: OUT_WIDTH];
    end
  end

endmodule
